alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Execute-stage front end for the superscalar RV32I core: accepts decoded integer instructions from the decode/rename side, maps each to the 4-bit ALU operation code and operand pair, buffers them in a small FIFO, drives the combinational ALU from the FIFO head, and registers the result with its destination tag for writeback. It sits directly upstream of the ALU, which it feeds, and directly upstream of writeback, which consumes its result. Both sides use valid/ready handshakes.

## Interface
- `DEPTH`, 2: FIFO entries; power of two, ≥2.
- `TAG_W`, 5: destination register tag width.

- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `flush`  in  1  synchronous pipeline flush.
- `in_valid`  in  1  decoded instruction present.
- `in_ready`  out  1  stage can accept.
- `in_kind`  in  3  0 OP, 1 OP-IMM, 2 LUI, 3 AUIPC, 4 LINK (JAL/JALR return address); 5–7 illegal.
- `in_funct3`  in  3  funct3 field.
- `in_f7b5`  in  1  funct7 bit 5 (instr[30]).
- `in_rs1`, `in_rs2`, `in_imm`, `in_pc`  in  32 each  operands, sign-extended immediate, instruction PC.
- `in_rd`  in  TAG_W  destination tag.
- `alu_op`  out  4  to ALU operation input.
- `alu_arg1`, `alu_arg2`  out  32 each  to ALU operands.
- `alu_result`  in  32  from ALU (combinational).
- `out_valid`  out  1  result register valid.
- `out_ready`  in  1  writeback accepts.
- `out_result`  out  32  registered result.
- `out_rd`  out  TAG_W  registered tag.
- `out_illegal`  out  1  entry had illegal kind.

## Operation
- ALU codes: 0 add, 1 sub, 2 or, 3 and, 4 xor, 5 sll, 6 srl, 7 sra, 8 slt, 9 sltu.
- Decode happens at push; the FIFO stores op, arg1, arg2, rd and the illegal flag.
- Decode for OP and OP-IMM (arg1 = rs1; arg2 = rs2 for OP, imm for OP-IMM), by funct3:
  - 000: add; sub only if OP and f7b5.
  - 001: sll. 010: slt. 011: sltu. 100: xor.
  - 101: srl, or sra if f7b5 (both kinds).
  - 110: or. 111: and.
- Other kinds:
  - LUI: add, arg1 = 0, arg2 = imm.
  - AUIPC: add, pc + imm.
  - LINK: add, pc + 32'd4; wraps mod 2^32.
  - Illegal kind: op = 0, args = 0, illegal = 1; out_result = 0.
- Push on `in_valid && in_ready`. `in_ready` = count != DEPTH, derived from state only; no combinational path from `out_ready`. When full, nothing is pushed, even if a pop occurs in the same cycle.
- Head drives `alu_*` whenever the FIFO is non-empty. When empty, `alu_*` are all zero.
- Load the output register (and pop the head) when head valid && (!out_valid || out_ready). Otherwise `out_valid` clears on `out_ready`.
- Push and pop in the same cycle are allowed when not full; count is unchanged. Pointers wrap mod DEPTH.
- `flush` has priority over everything:
  - Next cycle: count = 0, pointers = 0, out_valid = 0.
  - An input presented in the flush cycle is dropped.
  - Output data registers hold their values.
- Reset (async, any time, mid-transfer included): count, pointers, out_valid, out_result, out_rd and out_illegal all 0. `in_ready` = 1 after reset deasserts.

## Timing
- Latency (no bypass): push at edge N → output register loads at edge N+1 → `out_valid` high in cycle N+2.
- Throughput 1/cycle with `out_ready` held high.
- Backpressure: with `out_ready` low, the stage absorbs DEPTH entries plus 1 in the output register, then `in_ready` drops.
- Output fields stable while `out_valid && !out_ready`.

## Configuration
- `ALU_ISSUE_BYPASS_EN` defined: when the FIFO is empty and the output register can load, the input is decoded straight to `alu_*` and loads the output register the same edge (no FIFO write). Latency 1 cycle; ordering is preserved because bypass is used only when empty.
- Undefined: all traffic goes through the FIFO; latency 2.

## Test plan
- Reset, then OP funct3 000 f7b5=1, rs1=10, rs2=3, rd=7 → out_result=7, out_rd=7, out_valid at cycle 2 (cycle 1 with bypass).
- OP-IMM funct3 101 f7b5=1, rs1=0x80000000, imm=4 → 0xF8000000; OP-IMM 000 with f7b5=1, imm=−1, rs1=5 → 4 (no SUBI).
- LUI imm=0x12345000 → 0x12345000; AUIPC pc=0x100, imm=0x1000 → 0x1100; LINK pc=0xFFFFFFFC → 0; kind 6 → out_illegal=1, result 0.
- Hold out_ready=0, stream 4 ops → in_ready low after 3 accepted; release → results emerge in order, one per cycle.
- Fill FIFO, assert flush with in_valid=1 → next cycle out_valid=0, in_ready=1, flushed input never appears.
- Assert reset asynchronously mid-stream → out_valid=0, out_result=0 immediately, in_ready=1 after release.

Source files
------------

// File: rtl/alu_issue_stage_if.sv
// rtl/alu_issue_stage_if.sv - decode-side input, ALU drive and writeback handshake bundle for alu_issue_stage
interface alu_issue_stage_if #(
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_kind;
  logic [2:0]       in_funct3;
  logic             in_f7b5;
  logic [31:0]      in_rs1;
  logic [31:0]      in_rs2;
  logic [31:0]      in_imm;
  logic [31:0]      in_pc;
  logic [TAG_W-1:0] in_rd;

  logic [3:0]       alu_op;
  logic [31:0]      alu_arg1;
  logic [31:0]      alu_arg2;
  logic [31:0]      alu_result;

  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_rd;
  logic             out_illegal;

  modport slave (
    input  in_valid, in_kind, in_funct3, in_f7b5, in_rs1, in_rs2, in_imm, in_pc, in_rd,
    output in_ready,
    output alu_op, alu_arg1, alu_arg2,
    input  alu_result,
    output out_valid, out_result, out_rd, out_illegal,
    input  out_ready
  );

  modport master (
    output in_valid, in_kind, in_funct3, in_f7b5, in_rs1, in_rs2, in_imm, in_pc, in_rd,
    input  in_ready,
    input  alu_op, alu_arg1, alu_arg2,
    output alu_result,
    input  out_valid, out_result, out_rd, out_illegal,
    output out_ready
  );
endinterface

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - RV32I execute front end: decode to ALU op, FIFO, registered writeback result
// Optional macro ALU_ISSUE_BYPASS_EN routes input straight to the ALU when the FIFO is empty.
module alu_issue_stage #(
  parameter int DEPTH = 2,
  parameter int TAG_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  alu_issue_stage_if.slave  bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  localparam logic [2:0] KIND_OP     = 3'd0;
  localparam logic [2:0] KIND_OP_IMM = 3'd1;
  localparam logic [2:0] KIND_LUI    = 3'd2;
  localparam logic [2:0] KIND_AUIPC  = 3'd3;
  localparam logic [2:0] KIND_LINK   = 3'd4;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_OR   = 4'd2,
    OP_AND  = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9
  } alu_op_e;

  typedef struct packed {
    logic [3:0]       op;
    logic [31:0]      arg1;
    logic [31:0]      arg2;
    logic [TAG_W-1:0] rd;
    logic             illegal;
  } entry_t;

  entry_t            mem_q [DEPTH];
  entry_t            mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_result_q, out_result_d;
  logic [TAG_W-1:0]  out_rd_q, out_rd_d;
  logic              out_illegal_q, out_illegal_d;

  entry_t in_dec;
  entry_t issue;
  logic   empty;
  logic   full;
  logic   can_load;
  logic   bypass;
  logic   push;
  logic   pop;

  function automatic entry_t decode(
    input logic [2:0]       kind,
    input logic [2:0]       funct3,
    input logic             f7b5,
    input logic [31:0]      rs1,
    input logic [31:0]      rs2,
    input logic [31:0]      imm,
    input logic [31:0]      pc,
    input logic [TAG_W-1:0] rd
  );
    entry_t e;
    e    = '0;
    e.rd = rd;
    case (kind)
      KIND_OP, KIND_OP_IMM: begin
        e.arg1 = rs1;
        e.arg2 = (kind == KIND_OP) ? rs2 : imm;
        case (funct3)
          3'b000:  e.op = (kind == KIND_OP && f7b5) ? OP_SUB : OP_ADD;
          3'b001:  e.op = OP_SLL;
          3'b010:  e.op = OP_SLT;
          3'b011:  e.op = OP_SLTU;
          3'b100:  e.op = OP_XOR;
          3'b101:  e.op = f7b5 ? OP_SRA : OP_SRL;
          3'b110:  e.op = OP_OR;
          default: e.op = OP_AND;
        endcase
      end
      KIND_LUI: begin
        e.op   = OP_ADD;
        e.arg2 = imm;
      end
      KIND_AUIPC: begin
        e.op   = OP_ADD;
        e.arg1 = pc;
        e.arg2 = imm;
      end
      KIND_LINK: begin
        e.op   = OP_ADD;
        e.arg1 = pc;
        e.arg2 = 32'd4;
      end
      default: e.illegal = 1'b1;
    endcase
    return e;
  endfunction

  always_comb begin
    in_dec   = decode(bus.in_kind, bus.in_funct3, bus.in_f7b5, bus.in_rs1,
                      bus.in_rs2, bus.in_imm, bus.in_pc, bus.in_rd);
    empty    = (count_q == '0);
    full     = (count_q == FULL_CNT);
    can_load = !out_valid_q || bus.out_ready;
`ifdef ALU_ISSUE_BYPASS_EN
    bypass   = empty && bus.in_valid && can_load && !flush;
`else
    bypass   = 1'b0;
`endif
    // A full FIFO refuses input even when the head pops this cycle.
    push     = bus.in_valid && !full && !bypass && !flush;
    pop      = !empty && can_load && !flush;

    if (!empty) begin
      issue = mem_q[rd_ptr_q];
    end else if (bypass) begin
      issue = in_dec;
    end else begin
      issue = '0;
    end
  end

  assign bus.in_ready    = !full;
  assign bus.alu_op      = issue.op;
  assign bus.alu_arg1    = issue.arg1;
  assign bus.alu_arg2    = issue.arg2;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_result  = out_result_q;
  assign bus.out_rd      = out_rd_q;
  assign bus.out_illegal = out_illegal_q;

  always_comb begin
    mem_d         = mem_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    out_valid_d   = out_valid_q;
    out_result_d  = out_result_q;
    out_rd_d      = out_rd_q;
    out_illegal_d = out_illegal_q;

    // Flush empties the queue but leaves the output data fields as they were.
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      out_valid_d = 1'b0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = in_dec;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);

      if (pop || bypass) begin
        out_valid_d   = 1'b1;
        out_result_d  = issue.illegal ? 32'd0 : bus.alu_result;
        out_rd_d      = issue.rd;
        out_illegal_d = issue.illegal;
      end else if (bus.out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_rd_q      <= '0;
      out_illegal_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      out_valid_q   <= out_valid_d;
      out_result_q  <= out_result_d;
      out_rd_q      <= out_rd_d;
      out_illegal_q <= out_illegal_d;
    end
  end

  // Entry payload is qualified by count, so it needs no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - scoreboard bench for alu_issue_stage with a behavioural ALU
module tb_alu_issue_stage;
  localparam int DEPTH = 2;
  localparam int TAG_W = 5;

  typedef struct packed {
    logic [2:0]       kind;
    logic [2:0]       f3;
    logic             f7;
    logic [31:0]      rs1;
    logic [31:0]      rs2;
    logic [31:0]      imm;
    logic [31:0]      pc;
    logic [TAG_W-1:0] rd;
  } stim_t;

  typedef struct packed {
    logic [31:0]      res;
    logic [TAG_W-1:0] rd;
    logic             ill;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  int   n_tests = 0;
  int   n_fail  = 0;
  stim_t stim_q[$];
  exp_t  sb[$];

  always #5 clk = ~clk;

  alu_issue_stage_if #(.TAG_W(TAG_W)) bus ();

  alu_issue_stage #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  // Downstream ALU, keyed on the operation code only.
  always_comb begin
    case (bus.alu_op)
      4'd0:    bus.alu_result = bus.alu_arg1 + bus.alu_arg2;
      4'd1:    bus.alu_result = bus.alu_arg1 - bus.alu_arg2;
      4'd2:    bus.alu_result = bus.alu_arg1 | bus.alu_arg2;
      4'd3:    bus.alu_result = bus.alu_arg1 & bus.alu_arg2;
      4'd4:    bus.alu_result = bus.alu_arg1 ^ bus.alu_arg2;
      4'd5:    bus.alu_result = bus.alu_arg1 << bus.alu_arg2[4:0];
      4'd6:    bus.alu_result = bus.alu_arg1 >> bus.alu_arg2[4:0];
      4'd7:    bus.alu_result = 32'($signed(bus.alu_arg1) >>> bus.alu_arg2[4:0]);
      4'd8:    bus.alu_result = {31'd0, $signed(bus.alu_arg1) < $signed(bus.alu_arg2)};
      4'd9:    bus.alu_result = {31'd0, bus.alu_arg1 < bus.alu_arg2};
      default: bus.alu_result = 32'hDEAD_BEEF;
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Architectural result of one instruction, written from RV32I semantics.
  function automatic exp_t expect_of(input stim_t s);
    exp_t        e;
    logic [31:0] b;
    e     = '0;
    e.rd  = s.rd;
    b     = (s.kind == 3'd0) ? s.rs2 : s.imm;
    case (s.kind)
      3'd0, 3'd1: begin
        case (s.f3)
          3'b000:  e.res = (s.kind == 3'd0 && s.f7) ? s.rs1 - b : s.rs1 + b;
          3'b001:  e.res = s.rs1 << b[4:0];
          3'b010:  e.res = ($signed(s.rs1) < $signed(b)) ? 32'd1 : 32'd0;
          3'b011:  e.res = (s.rs1 < b) ? 32'd1 : 32'd0;
          3'b100:  e.res = s.rs1 ^ b;
          3'b101:  e.res = s.f7 ? 32'($signed(s.rs1) >>> b[4:0]) : s.rs1 >> b[4:0];
          3'b110:  e.res = s.rs1 | b;
          default: e.res = s.rs1 & b;
        endcase
      end
      3'd2:    e.res = s.imm;
      3'd3:    e.res = s.pc + s.imm;
      3'd4:    e.res = s.pc + 32'd4;
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  function automatic stim_t mk(input logic [2:0] kind, input logic [2:0] f3, input logic f7,
                               input logic [31:0] rs1, input logic [31:0] rs2,
                               input logic [31:0] imm, input logic [31:0] pc,
                               input logic [TAG_W-1:0] rd);
    stim_t s;
    s = '{kind: kind, f3: f3, f7: f7, rs1: rs1, rs2: rs2, imm: imm, pc: pc, rd: rd};
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.kind = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
    s.f3   = 3'($urandom_range(0, 7));
    s.f7   = 1'($urandom_range(0, 1));
    s.rs1  = $urandom;
    s.rs2  = $urandom;
    s.imm  = $urandom;
    s.pc   = $urandom;
    s.rd   = TAG_W'($urandom_range(0, 31));
    return s;
  endfunction

  task automatic present();
    if (stim_q.size() > 0) begin
      bus.in_valid  = 1'b1;
      bus.in_kind   = stim_q[0].kind;
      bus.in_funct3 = stim_q[0].f3;
      bus.in_f7b5   = stim_q[0].f7;
      bus.in_rs1    = stim_q[0].rs1;
      bus.in_rs2    = stim_q[0].rs2;
      bus.in_imm    = stim_q[0].imm;
      bus.in_pc     = stim_q[0].pc;
      bus.in_rd     = stim_q[0].rd;
    end else begin
      bus.in_valid  = 1'b0;
    end
  endtask

  // One clock: score the output handshake, record the input handshake, advance.
  task automatic tick();
    exp_t e;
    if (bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check_eq("spurious_out", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check_eq("result", bus.out_result, e.res);
        check_eq("rd", 32'(bus.out_rd), 32'(e.rd));
        check_eq("illegal", 32'(bus.out_illegal), 32'(e.ill));
      end
    end
    if (bus.in_valid && flush) begin
      void'(stim_q.pop_front());
    end else if (bus.in_valid && bus.in_ready) begin
      sb.push_back(expect_of(stim_q[0]));
      void'(stim_q.pop_front());
    end
    if (flush) sb.delete();
    @(posedge clk);
    @(negedge clk);
    present();
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    bus.out_ready = 1'b1;
    present();
    while ((sb.size() > 0 || stim_q.size() > 0 || bus.out_valid) && budget < 300) begin
      tick();
      budget++;
    end
    check_eq("drain_done", 32'(sb.size() + stim_q.size()), 32'd0);
  endtask

  initial begin
    int lat;
    int acc;
    int seen;
    logic [31:0] held;

    reset         = 1'b1;
    flush         = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_kind   = '0;
    bus.in_funct3 = '0;
    bus.in_f7b5   = 1'b0;
    bus.in_rs1    = '0;
    bus.in_rs2    = '0;
    bus.in_imm    = '0;
    bus.in_pc     = '0;
    bus.in_rd     = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_out_result", bus.out_result, 32'd0);
    check_eq("rst_out_rd", 32'(bus.out_rd), 32'd0);
    check_eq("rst_out_illegal", 32'(bus.out_illegal), 32'd0);
    check_eq("rst_alu_op", 32'(bus.alu_op), 32'd0);

    // Latency of a lone SUB into an idle stage.
    bus.out_ready = 1'b1;
    stim_q.push_back(mk(3'd0, 3'b000, 1'b1, 32'd10, 32'd3, 32'd0, 32'd0, 5'd7));
    present();
    tick();
    lat = 1;
`ifndef ALU_ISSUE_BYPASS_EN
    check_eq("head_alu_op", 32'(bus.alu_op), 32'd1);
    check_eq("head_alu_arg1", bus.alu_arg1, 32'd10);
    check_eq("head_alu_arg2", bus.alu_arg2, 32'd3);
`endif
    while (!bus.out_valid && lat < 10) begin
      tick();
      lat++;
    end
`ifdef ALU_ISSUE_BYPASS_EN
    check_eq("latency", 32'(lat), 32'd1);
`else
    check_eq("latency", 32'(lat), 32'd2);
`endif
    drain();

    // Directed decode corners.
    stim_q.push_back(mk(3'd1, 3'b101, 1'b1, 32'h8000_0000, 32'd0, 32'd4, 32'd0, 5'd1));
    stim_q.push_back(mk(3'd1, 3'b000, 1'b1, 32'd5, 32'd99, 32'hFFFF_FFFF, 32'd0, 5'd2));
    stim_q.push_back(mk(3'd2, 3'b000, 1'b0, 32'h1111, 32'h2222, 32'h1234_5000, 32'h40, 5'd3));
    stim_q.push_back(mk(3'd3, 3'b000, 1'b0, 32'h1111, 32'h2222, 32'h0000_1000, 32'h100, 5'd4));
    stim_q.push_back(mk(3'd4, 3'b000, 1'b0, 32'h1111, 32'h2222, 32'h0000_0008, 32'hFFFF_FFFC, 5'd5));
    stim_q.push_back(mk(3'd6, 3'b000, 1'b0, 32'h1111, 32'h2222, 32'h0000_0008, 32'h100, 5'd6));
    stim_q.push_back(mk(3'd0, 3'b101, 1'b0, 32'h8000_0000, 32'd31, 32'd0, 32'd0, 5'd8));
    stim_q.push_back(mk(3'd0, 3'b010, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 5'd9));
    stim_q.push_back(mk(3'd0, 3'b011, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 5'd10));
    drain();

    // Backpressure: two FIFO entries plus the output register, then stall.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      stim_q.push_back(mk(3'd1, 3'b000, 1'b0, 32'd100 * (i + 1), 32'd0, 32'd1, 32'd0, TAG_W'(11 + i)));
    present();
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.in_valid && bus.in_ready) acc++;
      tick();
    end
    check_eq("bp_accepted", 32'(acc), 32'd3);
    check_eq("bp_in_ready", 32'(bus.in_ready), 32'd0);
    check_eq("bp_out_valid", 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq("bp_stream_valid", 32'(bus.out_valid), 32'd1);
      tick();
    end
    drain();

    // Random traffic with random writeback stalls.
    for (int i = 0; i < 60; i++) stim_q.push_back(rand_stim());
    present();
    for (int i = 0; i < 150 && stim_q.size() > 0; i++) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    drain();

    // Flush with a full stage and an input presented in the flush cycle.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      stim_q.push_back(mk(3'd2, 3'b000, 1'b0, 32'd0, 32'd0, 32'hA000 + 32'(i), 32'd0, TAG_W'(20 + i)));
    present();
    for (int i = 0; i < 4; i++) tick();
    check_eq("fill_level", 32'(sb.size()), 32'd3);
    held = sb[0].res;
    stim_q.push_back(mk(3'd2, 3'b000, 1'b0, 32'd0, 32'd0, 32'hBAD0_0000, 32'd0, 5'd31));
    flush = 1'b1;
    present();
    tick();
    flush = 1'b0;
    check_eq("flush_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("flush_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("flush_hold_result", bus.out_result, held);
    bus.out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.out_valid) seen++;
      tick();
    end
    check_eq("flush_no_output", 32'(seen), 32'd0);
    stim_q.push_back(mk(3'd0, 3'b110, 1'b0, 32'h0F0, 32'h00F, 32'd0, 32'd0, 5'd12));
    drain();

    // Asynchronous reset in the middle of a stream.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++)
      stim_q.push_back(mk(3'd3, 3'b000, 1'b0, 32'd0, 32'd0, 32'h10, 32'h1000 * (i + 1), TAG_W'(i + 1)));
    present();
    for (int i = 0; i < 3; i++) tick();
    check_eq("pre_reset_valid", 32'(bus.out_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("arst_out_result", bus.out_result, 32'd0);
    check_eq("arst_out_rd", 32'(bus.out_rd), 32'd0);
    sb.delete();
    stim_q.delete();
    present();
    @(negedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
    check_eq("post_reset_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("post_reset_out_valid", 32'(bus.out_valid), 32'd0);
    stim_q.push_back(mk(3'd0, 3'b001, 1'b0, 32'd1, 32'd31, 32'd0, 32'd0, 5'd13));
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
